// File: rtl/register_file_32x32_if.sv
// Register-file port bundle: one write port, two operand read ports, one debug read port.
interface register_file_32x32_if #(
  parameter int WIDTH = 32
);
  logic             WE;
  logic [31:0]      WSEL;
  logic [WIDTH-1:0] WD;
  logic [4:0]       A1;
  logic [4:0]       A2;
  logic [4:0]       ADBG;
  logic [WIDTH-1:0] RD1;
  logic [WIDTH-1:0] RD2;
  logic [WIDTH-1:0] RDDBG;
  logic             SEL_ERR;
  logic [15:0]      WR_CNT;

  modport master (
    output WE, WSEL, WD, A1, A2, ADBG,
    input  RD1, RD2, RDDBG, SEL_ERR, WR_CNT
  );

  modport slave (
    input  WE, WSEL, WD, A1, A2, ADBG,
    output RD1, RD2, RDDBG, SEL_ERR, WR_CNT
  );
endinterface

// File: rtl/register_file_32x32.sv
// 31 x WIDTH register file (x0 hardwired to zero), one-hot write select, optional
// write-to-read forwarding on the operand ports, sticky select-error flag, saturating write count.
module register_file_32x32 #(
  parameter int WIDTH  = 32,
  parameter bit BYPASS = 1'b1
) (
  input logic                  CLK,
  input logic                  RESET,
  register_file_32x32_if.slave bus
);
  localparam int NUM_REGS = 32;

  logic [WIDTH-1:0] mem [1:NUM_REGS-1];
  logic [4:0]       widx;
  logic             onehot;
  logic             commit;
  logic             sel_err;
  logic [15:0]      wr_cnt;

  // OR-encode the select; only meaningful when it is one-hot.
  always_comb begin
    widx = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (bus.WSEL[i]) widx = widx | 5'(i);
  end

  assign onehot = (bus.WSEL != '0) && ((bus.WSEL & (bus.WSEL - 32'd1)) == '0);
  // A legal write to x0 is accepted but never commits.
  assign commit = !RESET && bus.WE && onehot && (widx != '0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 1; i < NUM_REGS; i++) mem[i] <= '0;
      sel_err <= 1'b0;
      wr_cnt  <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++)
        if (commit && widx == 5'(i)) mem[i] <= bus.WD;
      if (bus.WE && !onehot) sel_err <= 1'b1;
      if (commit && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
    end
  end

  function automatic logic [WIDTH-1:0] rd_mem(input logic [4:0] a);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 1; i < NUM_REGS; i++)
      if (a == 5'(i)) v = mem[i];
    return v;
  endfunction

  logic fwd1, fwd2;
  // commit already excludes reset and x0, so forwarding inherits both exclusions.
  assign fwd1 = BYPASS && commit && (widx == bus.A1);
  assign fwd2 = BYPASS && commit && (widx == bus.A2);

  assign bus.RD1     = fwd1 ? bus.WD : rd_mem(bus.A1);
  assign bus.RD2     = fwd2 ? bus.WD : rd_mem(bus.A2);
  assign bus.RDDBG   = rd_mem(bus.ADBG);
  assign bus.SEL_ERR = sel_err;
  assign bus.WR_CNT  = wr_cnt;
endmodule

// File: tb/tb_register_file_32x32.sv
module tb_register_file_32x32;
  logic CLK = 1'b0;
  logic RESET;

  register_file_32x32_if #(.WIDTH(32)) bus ();
  register_file_32x32 #(.WIDTH(32), .BYPASS(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  localparam int S_RD1 = 0, S_RD2 = 1, S_DBG = 2, S_ERR = 3, S_CNT = 4;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] exp;
    string       nm;
  } chk_t;

  chk_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] sample(input int sig);
    case (sig)
      S_RD1:   return bus.RD1;
      S_RD2:   return bus.RD2;
      S_DBG:   return bus.RDDBG;
      S_ERR:   return {31'd0, bus.SEL_ERR};
      default: return {16'd0, bus.WR_CNT};
    endcase
  endfunction

  always @(negedge CLK) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      chk_t c;
      logic [31:0] got;
      c = q.pop_front();
      got = sample(c.sig);
      checks++;
      if (got === c.exp) passed++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", c.nm, got, c.exp, c.cyc);
    end
  end

  task automatic chk(input string nm, input int sig, input logic [31:0] v);
    q.push_back('{cyc, sig, v, nm});
  endtask

  task automatic drive(input logic rst, input logic we, input logic [31:0] wsel,
                       input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] adbg);
    RESET = rst; bus.WE = we; bus.WSEL = wsel; bus.WD = wd;
    bus.A1 = a1; bus.A2 = a2; bus.ADBG = adbg;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1, 0, 32'h0, 32'h0, 0, 0, 0);
    tick(); tick();

    drive(0, 0, 32'h0, 32'h0, 5, 31, 0);
    chk("rst_rd1", S_RD1, 0); chk("rst_rd2", S_RD2, 0); chk("rst_dbg", S_DBG, 0);
    chk("rst_err", S_ERR, 0); chk("rst_cnt", S_CNT, 0);
    tick();

    drive(0, 1, 32'h0000_0020, 32'hDEADBEEF, 0, 0, 5);
    chk("x0_rd1_during_wr", S_RD1, 0); chk("dbg_no_fwd_first", S_DBG, 0);
    tick();

    drive(0, 0, 32'h0, 32'h0, 5, 0, 0);
    chk("x5_readback", S_RD1, 32'hDEADBEEF); chk("cnt_1", S_CNT, 1); chk("err_0", S_ERR, 0);
    tick();

    drive(0, 1, 32'h0000_0020, 32'h12345678, 5, 5, 5);
    chk("byp_rd1", S_RD1, 32'h12345678); chk("byp_rd2", S_RD2, 32'h12345678);
    chk("dbg_old", S_DBG, 32'hDEADBEEF);
    tick();

    drive(0, 1, 32'h0000_0002, 32'h11111111, 2, 1, 5);
    chk("dbg_new", S_DBG, 32'h12345678); chk("cnt_2", S_CNT, 2);
    chk("nomatch_rd1", S_RD1, 0); chk("byp_x1_rd2", S_RD2, 32'h11111111);
    tick();

    drive(0, 1, 32'h0000_0004, 32'h22222222, 1, 0, 0);
    chk("x1_readback", S_RD1, 32'h11111111); chk("cnt_3", S_CNT, 3);
    tick();

    drive(0, 1, 32'h0000_0001, 32'hFFFFFFFF, 0, 0, 0);
    chk("x0_no_byp_rd1", S_RD1, 0); chk("x0_no_byp_rd2", S_RD2, 0); chk("cnt_4", S_CNT, 4);
    tick();

    drive(0, 0, 32'h0, 32'h0, 0, 2, 0);
    chk("x0_still_0", S_RD1, 0); chk("x0_cnt_4", S_CNT, 4); chk("x0_err_0", S_ERR, 0);
    chk("x2_readback", S_RD2, 32'h22222222);
    tick();

    drive(0, 1, 32'h0000_0006, 32'hAAAAAAAA, 1, 2, 0);
    chk("twohot_no_byp1", S_RD1, 32'h11111111); chk("twohot_no_byp2", S_RD2, 32'h22222222);
    chk("twohot_err_pre", S_ERR, 0);
    tick();

    drive(0, 0, 32'h0, 32'h0, 1, 2, 0);
    chk("twohot_x1", S_RD1, 32'h11111111); chk("twohot_x2", S_RD2, 32'h22222222);
    chk("twohot_err", S_ERR, 1); chk("twohot_cnt", S_CNT, 4);
    tick();

    drive(0, 1, 32'h0, 32'hBBBBBBBB, 1, 2, 0);
    tick();

    drive(0, 0, 32'hFFFF_FFFF, 32'hCCCCCCCC, 1, 2, 0);
    chk("zsel_x1", S_RD1, 32'h11111111); chk("zsel_x2", S_RD2, 32'h22222222);
    chk("zsel_cnt", S_CNT, 4); chk("err_held", S_ERR, 1);
    tick();

    drive(0, 0, 32'h0, 32'h0, 1, 2, 0);
    chk("we0_x1", S_RD1, 32'h11111111); chk("we0_x2", S_RD2, 32'h22222222);
    chk("err_held2", S_ERR, 1);
    tick();

    drive(1, 1, 32'h8000_0000, 32'hA5A5A5A5, 31, 5, 0);
    chk("rst_no_byp", S_RD1, 0); chk("rst_stored_x5", S_RD2, 32'h12345678);
    tick();

    drive(0, 0, 32'h0, 32'h0, 31, 5, 1);
    chk("rst_x31", S_RD1, 0); chk("rst_x5", S_RD2, 0); chk("rst_x1_dbg", S_DBG, 0);
    chk("rst_cnt_0", S_CNT, 0); chk("rst_err_0", S_ERR, 0);
    tick();

    for (int i = 0; i < 65540; i++) begin
      drive(0, 1, 32'h0000_0080, 32'(i), 0, 0, 0);
      if (i == 65535) chk("cnt_reach_ffff", S_CNT, 32'h0000_FFFF);
      tick();
    end
    drive(0, 0, 32'h0, 32'h0, 7, 0, 0);
    chk("cnt_sat", S_CNT, 32'h0000_FFFF); chk("x7_last", S_RD1, 32'd65539);
    tick();
    @(negedge CLK);
    #1;

    checks++;
    if (bus.WR_CNT === 16'hFFFF) passed++;
    else $display("FAIL final_cnt: got %h expected ffff", bus.WR_CNT);
    checks++;
    if (bus.SEL_ERR === 1'b0) passed++;
    else $display("FAIL final_err: got %b expected 0", bus.SEL_ERR);
    checks++;
    if (bus.RD1 === 32'd65539) passed++;
    else $display("FAIL final_x7: got %h expected %h", bus.RD1, 32'd65539);

    while (q.size() > 0) begin
      chk_t c;
      c = q.pop_front();
      checks++;
      $display("FAIL %s: got unchecked expected checked (cycle %0d)", c.nm, c.cyc);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/register_file_32x32.md
REGISTER_FILE_32X32 -- requirements
Module: register_file_32x32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of every register and data port.
REQ-002 SHALL have parameter BYPASS, default 1, where 1 enables write-to-read forwarding and 0 disables it.
REQ-003 SHALL have port CLK  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port WE  input  1  global write enable from control unit.
REQ-006 SHALL have port WSEL  input  32  one-hot write-select from the 5-to-32 destination decoder.
REQ-007 SHALL have port WD  input  WIDTH  write data.
REQ-008 SHALL have port A1  input  5  read address, port 1 (rs1).
REQ-009 SHALL have port A2  input  5  read address, port 2 (rs2).
REQ-010 SHALL have port ADBG  input  5  debug read address.
REQ-011 SHALL have port RD1  output  WIDTH  read data, port 1.
REQ-012 SHALL have port RD2  output  WIDTH  read data, port 2.
REQ-013 SHALL have port RDDBG  output  WIDTH  debug read data, never bypassed.
REQ-014 SHALL have port SEL_ERR  output  1  sticky flag, illegal WSEL seen with WE=1.
REQ-015 SHALL have port WR_CNT  output  16  count of committed writes.

Function
REQ-016 SHALL hold registers x1..x31, each WIDTH bits; x0 SHALL have no storage and always read 0.
REQ-017 SHALL perform reads combinationally: RDn = reg[An], zero-latency, with x0 returning 0.
REQ-018 SHALL commit a write on a rising CLK edge only when RESET=0, WE=1, and WSEL has exactly one bit set; the register written is the index of that bit.
REQ-019 SHALL treat a legal write with WSEL=32'h0000_0001 (x0) as accepted but discarded: no state change, WR_CNT not incremented, SEL_ERR not set.
REQ-020 SHALL, when WE=1 and WSEL is zero or has two or more bits set, write no register, leave WR_CNT unchanged, and set SEL_ERR to 1 at that edge.
REQ-021 SHALL ignore WSEL entirely when WE=0, so no write occurs and SEL_ERR is not affected.
REQ-022 SHALL keep SEL_ERR at 1 until RESET.
REQ-023 SHALL increment WR_CNT by 1 on each committed write to x1..x31, saturating at 16'hFFFF with no wrap.
REQ-024 SHALL, when BYPASS=1, drive RD1 (RD2) with WD in the same cycle that WE=1, WSEL is legal one-hot, WSEL bit index equals A1 (A2), and that index is not 0.
REQ-025 SHALL, when BYPASS=0 or the forwarding condition in REQ-024 is false, drive stored data until the edge; new data is visible the cycle after the edge.
REQ-026 SHALL apply the same rule to simultaneous reads of one address on both ports: RD1 and RD2 both return the stored value, or both return the bypassed value.
REQ-027 SHALL never forward to RDDBG.

Reset
REQ-028 SHALL, on a rising edge with RESET=1, clear x1..x31 to 0, SEL_ERR to 0, and WR_CNT to 0.
REQ-029 SHALL give RESET priority over a write in the same cycle, so no register is written and WR_CNT stays 0.
REQ-030 SHALL suppress bypass while RESET=1, so reads return the stored or cleared values.
REQ-031 SHALL have all outputs read 0 for every address after reset.

Verification
REQ-032 SHALL cover this scenario: reset; WE=1, WSEL=32'h0000_0020, WD=32'hDEADBEEF; next cycle A1=5 -> RD1=32'hDEADBEEF, WR_CNT=1, SEL_ERR=0.
REQ-033 SHALL cover this scenario: BYPASS=1; in the write cycle A1=A2=5, WSEL=32'h0000_0020, WD=32'h12345678 -> RD1=RD2=32'h12345678 before the edge; RDDBG (ADBG=5) shows the old value.
REQ-034 SHALL cover this scenario: WE=1, WSEL=32'h0000_0001, WD=32'hFFFFFFFF -> A1=0 reads 0, WR_CNT unchanged, SEL_ERR=0.
REQ-035 SHALL cover this scenario: WE=1, WSEL=32'h0000_0006 -> x1 and x2 unchanged, SEL_ERR=1 from the next cycle and held; WE=1, WSEL=0 -> no write.
REQ-036 SHALL cover this scenario: RESET=1 together with WE=1, WSEL=32'h8000_0000, WD=32'hA5A5A5A5 -> x31 reads 0 after the edge, WR_CNT=0.
REQ-037 SHALL cover this scenario: 65540 legal writes to x7 -> WR_CNT=16'hFFFF, not wrapped.
